// File: rtl/cpu_bus_pkg.sv
// Shared constants for the CPU tri-state bus read path.
// State encodings, the "no source selected" cs pattern and the error fill word.
package cpu_bus_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;
   localparam logic [1:0] ST_TURN  = 2'd3;

   localparam logic [63:0] CS_NONE  = '1;
   localparam logic [63:0] ERR_FILL = '1;

endpackage

// File: rtl/bus_cs_decoder.sv
// Index plus enable to active-low one-hot chip-select vector.
// With the enable low every source stays tri-stated.
module bus_cs_decoder #(
   parameter int NrOfSources = 4,
   parameter int SelBits     = 2
) (
   input  logic [SelBits-1:0]     i_idx,
   input  logic                   i_en,
   output logic [NrOfSources-1:0] o_cs_n
);

   always_comb begin
      o_cs_n = '1;
      for (int i = 0; i < NrOfSources; i++) begin
         o_cs_n[i] = ~(i_en && (i_idx == SelBits'(i)));
      end
   end

endmodule

// File: rtl/bus_read_sequencer.sv
// Read initiator for the shared tri-state bus: one cs low, settle, capture, respond.
// Define BUS_TURNAROUND_EN to force one idle bus tick (TURN) between reads.
module bus_read_sequencer
   import cpu_bus_pkg::*;
#(
   parameter int NrOfBits    = 8,
   parameter int NrOfSources = 4,
   parameter int SelBits     = 2,
   parameter int SampleDelay = 1
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic                   Tick,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [SelBits-1:0]     req_sel,
   output logic [NrOfSources-1:0] cs_n,
   input  logic [NrOfBits-1:0]    bus,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [NrOfBits-1:0]    rsp_data,
   output logic                   rsp_err,
   output logic                   busy
);

   localparam int Dly  = (SampleDelay < 1) ? 1 : SampleDelay;
   localparam int CntL = $clog2(SampleDelay + 1);
   localparam int CntW = (CntL < 1) ? 1 : CntL;

   localparam logic [CntW-1:0]    CNT_LOAD = CntW'(Dly);
   localparam logic [CntW-1:0]    CNT_ONE  = CntW'(1);
   localparam logic [SelBits:0]   SRC_LIM  = (SelBits + 1)'(NrOfSources);
   localparam logic [NrOfSources-1:0] CS_IDLE = CS_NONE[NrOfSources-1:0];
   localparam logic [NrOfBits-1:0]    FILL    = ERR_FILL[NrOfBits-1:0];

   logic [1:0]             r_state;
   logic [CntW-1:0]        r_cnt;
   logic [NrOfSources-1:0] r_cs_n;
   logic                   r_rsp_valid;
   logic [NrOfBits-1:0]    r_rsp_data;
   logic                   r_rsp_err;

   logic                   w_sel_ok;
   logic [NrOfSources-1:0] w_cs_dec;

   assign w_sel_ok = ({1'b0, req_sel} < SRC_LIM);

   bus_cs_decoder #(
      .NrOfSources (NrOfSources),
      .SelBits     (SelBits)
   ) u_dec (
      .i_idx  (req_sel),
      .i_en   (w_sel_ok),
      .o_cs_n (w_cs_dec)
   );

   assign req_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign cs_n      = r_cs_n;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_cs_n      <= CS_IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else if (Tick) begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_cnt <= CNT_LOAD;
                  if (w_sel_ok) begin
                     r_cs_n  <= w_cs_dec;
                     r_state <= ST_DRIVE;
                  end else begin
                     // No driver exists: answer at once, never touch the bus
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= FILL;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end
               end
            end
            ST_DRIVE: begin
               if (r_cnt == CNT_ONE) begin
                  r_rsp_data  <= bus;
                  r_cs_n      <= CS_IDLE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
`ifdef BUS_TURNAROUND_EN
                  r_state     <= ST_TURN;
`else
                  r_state     <= ST_IDLE;
`endif
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Directed bench for bus_read_sequencer: vector table plus multi-cycle sequences.
// Expectations follow BUS_TURNAROUND_EN when it is defined for the build.
module tb_bus_read_sequencer;

`ifdef BUS_TURNAROUND_EN
   localparam int TURN = 1;
`else
   localparam int TURN = 0;
`endif

   logic       Clock = 1'b0;
   logic       Reset_n;
   logic       Tick;
   logic [2:0] sel;
   logic [7:0] bus;
   logic       rsp_ready;

   logic       req_valid0, req_ready0, rsp_valid0, rsp_err0, busy0;
   logic [3:0] cs_n0;
   logic [7:0] rsp_data0;

   logic       req_valid1, req_ready1, rsp_valid1, rsp_err1, busy1;
   logic [2:0] cs_n1;
   logic [7:0] rsp_data1;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   bus_read_sequencer #(
      .NrOfBits(8), .NrOfSources(4), .SelBits(3), .SampleDelay(1)
   ) u0 (
      .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_sel(sel),
      .cs_n(cs_n0), .bus(bus), .rsp_valid(rsp_valid0),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
      .busy(busy0)
   );

   bus_read_sequencer #(
      .NrOfBits(8), .NrOfSources(3), .SelBits(2), .SampleDelay(3)
   ) u1 (
      .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_sel(sel[1:0]),
      .cs_n(cs_n1), .bus(bus), .rsp_valid(rsp_valid1),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
      .busy(busy1)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // At most one driver enabled, and none while a response is held
   always @(negedge Clock) begin
      if (Reset_n === 1'b1) begin
         checks++;
         if ($countones(~cs_n0) > 1 || $countones(~cs_n1) > 1 ||
             (rsp_valid0 && cs_n0 != 4'hF) ||
             (rsp_valid1 && cs_n1 != 3'h7)) begin
            errors++;
            $display("FAIL cs_onehot: cs_n0=%b cs_n1=%b v0=%b v1=%b",
                     cs_n0, cs_n1, rsp_valid0, rsp_valid1);
         end
      end
   end

   typedef struct {
      logic [2:0] sel;
      logic [7:0] bus;
      logic [3:0] cs;
      logic       err;
      logic [7:0] data;
   } vec_t;

   vec_t vt[7];

   initial begin
      int bad, low_cyc, first_v, h, j;
      logic [2:0] lowmask;
      logic low_q[12];
      logic val_q[12];

      vt[0] = '{3'd1, 8'hA5, 4'b1101, 1'b0, 8'hA5};
      vt[1] = '{3'd0, 8'h3C, 4'b1110, 1'b0, 8'h3C};
      vt[2] = '{3'd2, 8'h00, 4'b1011, 1'b0, 8'h00};
      vt[3] = '{3'd3, 8'hFF, 4'b0111, 1'b0, 8'hFF};
      vt[4] = '{3'd4, 8'h12, 4'b1111, 1'b1, 8'hFF};
      vt[5] = '{3'd7, 8'h55, 4'b1111, 1'b1, 8'hFF};
      vt[6] = '{3'd3, 8'h81, 4'b0111, 1'b0, 8'h81};

      Reset_n = 1'b0;
      Tick = 1'b0; sel = '0; bus = '0; rsp_ready = 1'b0;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      step();
      chk("rst_cs0", cs_n0, 4'hF);
      chk("rst_cs1", cs_n1, 3'h7);
      chk("rst_valid", rsp_valid0, 0);
      chk("rst_data", rsp_data0, 0);
      chk("rst_err", rsp_err0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_rdy", req_ready0, 1);

      @(negedge Clock);
      Reset_n = 1'b1; Tick = 1'b1;

      for (int i = 0; i < 7; i++) begin
         @(negedge Clock);
         sel = vt[i].sel; bus = vt[i].bus;
         req_valid0 = 1'b1; rsp_ready = 1'b0;
         step();
         chk("vec_cs", cs_n0, vt[i].cs);
         chk("vec_busy", busy0, 1);
         if (!vt[i].err) begin
            chk("vec_early", rsp_valid0, 0);
            @(negedge Clock);
            req_valid0 = 1'b0;
            step();
            chk("vec_cs_rel", cs_n0, 4'hF);
         end
         chk("vec_valid", rsp_valid0, 1);
         chk("vec_data", rsp_data0, vt[i].data);
         chk("vec_err", rsp_err0, vt[i].err);
         @(negedge Clock);
         req_valid0 = 1'b0; rsp_ready = 1'b1;
         step();
         chk("vec_done", rsp_valid0, 0);
         chk("vec_busy_after", busy0, TURN);
         if (TURN != 0) begin
            @(negedge Clock);
            rsp_ready = 1'b0;
            step();
            chk("vec_turn_idle", busy0, 0);
         end
         @(negedge Clock);
         rsp_ready = 1'b0;
      end

      // Async reset in the middle of a DRIVE phase
      @(negedge Clock);
      sel = 3'd2; req_valid0 = 1'b1;
      step();
      chk("mid_cs", cs_n0, 4'b1011);
      #2 Reset_n = 1'b0;
      #1;
      chk("arst_cs", cs_n0, 4'hF);
      chk("arst_valid", rsp_valid0, 0);
      chk("arst_busy", busy0, 0);
      @(negedge Clock);
      Reset_n = 1'b1; req_valid0 = 1'b0;

      // SampleDelay=3 with Tick toggling, capture on third qualified edge
      low_cyc = 0; first_v = -1; lowmask = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clock);
         Tick = (k % 2 == 0);
         bus = 8'h40 + 8'(k);
         sel = 3'd2;
         req_valid1 = (k == 0);
         step();
         if (cs_n1 != 3'h7) low_cyc++;
         lowmask |= ~cs_n1;
         if (rsp_valid1 && first_v < 0) first_v = k;
      end
      chk("sd3_low_cycles", low_cyc, 6);
      chk("sd3_lowmask", lowmask, 3'b100);
      chk("sd3_first_valid", first_v, 6);
      chk("sd3_data", rsp_data1, 8'h46);
      chk("sd3_err", rsp_err1, 0);
      @(negedge Clock);
      Tick = 1'b1; rsp_ready = 1'b1;
      step();
      chk("sd3_done", rsp_valid1, 0);
      @(negedge Clock);
      rsp_ready = 1'b0;
      step();

      // Source index beyond NrOfSources=3
      @(negedge Clock);
      sel = 3'd3; req_valid1 = 1'b1;
      step();
      chk("oob_valid", rsp_valid1, 1);
      chk("oob_cs", cs_n1, 3'h7);
      chk("oob_data", rsp_data1, 8'hFF);
      chk("oob_err", rsp_err1, 1);
      @(negedge Clock);
      req_valid1 = 1'b0; rsp_ready = 1'b1;
      step();
      chk("oob_done", rsp_valid1, 0);
      @(negedge Clock);
      rsp_ready = 1'b0;
      step();

      // Response held off for 10 cycles while the bus keeps moving
      @(negedge Clock);
      sel = 3'd0; bus = 8'h11; req_valid0 = 1'b1;
      step();
      @(negedge Clock);
      req_valid0 = 1'b0;
      step();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         bus = 8'h20 + 8'(i);
         step();
         if (rsp_data0 != 8'h11 || req_ready0 || !rsp_valid0 || rsp_err0)
            bad++;
      end
      chk("hold_stable", bad, 0);
      @(negedge Clock);
      rsp_ready = 1'b1;
      step();
      chk("hold_release", rsp_valid0, 0);
      chk("hold_busy", busy0, TURN);
      chk("hold_rdy", req_ready0, 1 - TURN);
      @(negedge Clock);
      rsp_ready = 1'b0;
      step();
      chk("hold_idle", busy0, 0);

      // Back-to-back requests with req_valid and rsp_ready held high
      @(negedge Clock);
      sel = 3'd1; bus = 8'h77; req_valid0 = 1'b1; rsp_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         low_q[k] = (cs_n0 != 4'hF);
         val_q[k] = rsp_valid0;
      end
      h = -1; j = -1;
      for (int k = 1; k < 12; k++)
         if (h < 0 && val_q[k-1] && !val_q[k]) h = k;
      for (int k = 0; k < 12; k++)
         if (j < 0 && h >= 0 && k > h && low_q[k]) j = k;
      chk("b2b_first_cs", low_q[0], 1);
      chk("b2b_handshake", h, 2);
      chk("b2b_gap", j - h, 1 + TURN);
      chk("b2b_data", rsp_data0, 8'h77);

      @(negedge Clock);
      req_valid0 = 1'b0; rsp_ready = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
